rom_port_arbiter: RTL and testbench

Shares the single-port pattern ROM (11-bit address, 8-bit data, registered read) between the VGA pixel-fetch path and an auxiliary requester, such as a debug readback or character-table loader. Sits between `vga_control_*` / auxiliary logic and `rom_ip`, and drives the ROM address on every cycle.

---
 rtl/rom_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_rom_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// Arbitrates the single-port pattern ROM between the display fetch path (absolute
// priority, fixed latency) and a single-outstanding auxiliary read port.
module rom_port_arbiter #(
  parameter int AW      = 11,
  parameter int DW      = 8,
  parameter int ROM_LAT = 1,
  parameter int WCW     = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           disp_en,
  input  logic [AW-1:0]  disp_addr,
  output logic [DW-1:0]  disp_data,
  output logic           disp_valid,
  input  logic           aux_req,
  input  logic [AW-1:0]  aux_addr,
  output logic           aux_busy,
  output logic           aux_done,
  output logic [DW-1:0]  aux_rdata,
  output logic [WCW-1:0] aux_wait,
  output logic [AW-1:0]  rom_addr,
  input  logic [DW-1:0]  rom_data
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_AUX  = 2'd2
  } tag_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e          state_r;
  tag_e            tag_r [ROM_LAT+1];
  tag_e            issue_tag_s;
  tag_e            out_tag_s;
  logic [AW-1:0]   aux_addr_q_r;

  // Select who owns the ROM address this cycle; the display always wins.
  always_comb begin
    issue_tag_s = TAG_NONE;
    if (disp_en) begin
      issue_tag_s = TAG_DISP;
    end else if (state_r == ST_PEND) begin
      issue_tag_s = TAG_AUX;
    end else begin
      issue_tag_s = TAG_NONE;
    end
  end

  // The last tag stage lines up with the rom_data word being captured.
  assign out_tag_s = tag_r[ROM_LAT];

  // Issue register and tag pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= {AW{1'b0}};
      for (int i = 0; i <= ROM_LAT; i++) begin
        tag_r[i] <= TAG_NONE;
      end
    end else begin
      case (issue_tag_s)
        TAG_DISP: rom_addr <= disp_addr;
        TAG_AUX:  rom_addr <= aux_addr_q_r;
        default:  rom_addr <= rom_addr;
      endcase
      tag_r[0] <= issue_tag_s;
      for (int i = 1; i <= ROM_LAT; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  // Route returning ROM data to the port that issued it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_data  <= {DW{1'b0}};
      disp_valid <= 1'b0;
      aux_rdata  <= {DW{1'b0}};
      aux_done   <= 1'b0;
    end else begin
      case (out_tag_s)
        TAG_DISP: begin
          disp_data  <= rom_data;
          disp_valid <= 1'b1;
          aux_done   <= 1'b0;
        end
        TAG_AUX: begin
          aux_rdata  <= rom_data;
          aux_done   <= 1'b1;
          disp_valid <= 1'b0;
        end
        default: begin
          disp_valid <= 1'b0;
          aux_done   <= 1'b0;
        end
      endcase
    end
  end

  // Auxiliary request FSM with busy flag and saturating wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      aux_busy     <= 1'b0;
      aux_wait     <= {WCW{1'b0}};
      aux_addr_q_r <= {AW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (aux_req) begin
            aux_addr_q_r <= aux_addr;
            aux_wait     <= {WCW{1'b0}};
            aux_busy     <= 1'b1;
            state_r      <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (!disp_en) begin
            state_r <= ST_WAIT;
          end else if (aux_wait != {WCW{1'b1}}) begin
            aux_wait <= aux_wait + WCW'(1);
          end
        end
        ST_WAIT: begin
          if (out_tag_s == TAG_AUX) begin
            aux_busy <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        default: begin
          aux_busy <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: a behavioural ROM plus queue scoreboards
// for display and auxiliary read data.
module tb_rom_port_arbiter;

  localparam int AW      = 11;
  localparam int DW      = 8;
  localparam int ROM_LAT = 1;
  localparam int WCW     = 8;

  logic           clk;
  logic           rst_n;
  logic           disp_en;
  logic [AW-1:0]  disp_addr;
  logic [DW-1:0]  disp_data;
  logic           disp_valid;
  logic           aux_req;
  logic [AW-1:0]  aux_addr;
  logic           aux_busy;
  logic           aux_done;
  logic [DW-1:0]  aux_rdata;
  logic [WCW-1:0] aux_wait;
  logic [AW-1:0]  rom_addr;
  logic [DW-1:0]  rom_data;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } disp_exp_t;

  disp_exp_t     dq[$];
  logic [DW-1:0] aq[$];
  logic [DW-1:0] mem [1 << AW];
  int            cyc;
  int            n_chk;
  int            n_fail;

  rom_port_arbiter #(.AW(AW), .DW(DW), .ROM_LAT(ROM_LAT), .WCW(WCW)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_en(disp_en), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .aux_req(aux_req), .aux_addr(aux_addr), .aux_busy(aux_busy), .aux_done(aux_done),
    .aux_rdata(aux_rdata), .aux_wait(aux_wait), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read ROM, one cycle from address to data.
  always @(posedge clk) rom_data <= mem[rom_addr];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (disp_valid || (dq.size() > 0 && dq[0].due == cyc)) begin
      if (dq.size() == 0) begin
        check("disp_unexpected", 32'(disp_valid), 32'd0);
      end else begin
        check("disp_valid", 32'(disp_valid), 32'd1);
        check("disp_cycle", cyc, dq[0].due);
        check("disp_data", 32'(disp_data), 32'(dq[0].data));
        void'(dq.pop_front());
      end
    end
    if (aux_done) begin
      if (aq.size() == 0) begin
        check("aux_unexpected", 32'(aux_done), 32'd0);
      end else begin
        check("aux_rdata_sb", 32'(aux_rdata), 32'(aq[0]));
        void'(aq.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_disp(input logic [AW-1:0] a);
    disp_exp_t e;
    e.due  = cyc + ROM_LAT + 2;
    e.data = mem[a];
    dq.push_back(e);
  endtask

  // Waits for aux_done; busy_c counts busy samples starting with the current one.
  task automatic wait_aux(input int max, output int done_c, output int busy_c);
    busy_c = int'(aux_busy);
    done_c = -1;
    for (int n = 0; n < max; n++) begin
      step();
      if (aux_done) begin
        done_c = cyc;
        break;
      end
      busy_c += int'(aux_busy);
    end
    if (done_c < 0) check("aux_done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int req_c;
    int done_c;
    int busy_c;
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    for (int a = 0; a < (1 << AW); a++) mem[a] = DW'(a) + 8'h10;
    mem[11'h123] = 8'hA5;
    rst_n = 1'b0;
    disp_en = 1'b0;
    disp_addr = '0;
    aux_req = 1'b0;
    aux_addr = '0;

    // Reset values
    repeat (3) step();
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_disp_data", 32'(disp_data), 32'd0);
    check("rst_disp_valid", 32'(disp_valid), 32'd0);
    check("rst_aux_busy", 32'(aux_busy), 32'd0);
    check("rst_aux_done", 32'(aux_done), 32'd0);
    check("rst_aux_rdata", 32'(aux_rdata), 32'd0);
    check("rst_aux_wait", 32'(aux_wait), 32'd0);
    rst_n = 1'b1;
    step();

    // Display stream of 8 back-to-back fetches
    for (int i = 0; i < 8; i++) begin
      disp_en = 1'b1;
      disp_addr = AW'(i);
      push_disp(disp_addr);
      step();
    end
    disp_en = 1'b0;
    repeat (5) step();
    check("disp_drain", dq.size(), 32'd0);
    check("rom_addr_hold", 32'(rom_addr), 32'd7);

    // Idle auxiliary read
    aux_req = 1'b1;
    aux_addr = 11'h123;
    aq.push_back(mem[11'h123]);
    req_c = cyc + 1;
    step();
    aux_req = 1'b0;
    check("aux_busy_rise", 32'(aux_busy), 32'd1);
    wait_aux(50, done_c, busy_c);
    check("aux_idle_latency", done_c - req_c, 32'd3);
    check("aux_idle_busy_len", busy_c, 32'd3);
    check("aux_idle_busy_fall", 32'(aux_busy), 32'd0);
    check("aux_idle_rdata", 32'(aux_rdata), 32'hA5);
    check("aux_idle_wait", 32'(aux_wait), 32'd0);
    step();

    // Contention with a 10-cycle display burst
    req_c = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      disp_en = 1'b1;
      disp_addr = AW'(11'h040 + i);
      push_disp(disp_addr);
      if (i == 0) begin
        aux_req = 1'b1;
        aux_addr = 11'h2A0;
        aq.push_back(mem[11'h2A0]);
      end
      step();
      aux_req = 1'b0;
      check("cont_rom_addr", 32'(rom_addr), 32'(11'h040 + i));
    end
    check("cont_wait_cnt", 32'(aux_wait), 32'd9);
    check("cont_busy", 32'(aux_busy), 32'd1);
    disp_en = 1'b0;
    wait_aux(50, done_c, busy_c);
    check("cont_latency", done_c - req_c, 32'd12);
    check("cont_wait_final", 32'(aux_wait), 32'd9);
    repeat (3) step();
    check("cont_disp_drain", dq.size(), 32'd0);

    // Second request while busy is ignored
    aux_req = 1'b1;
    aux_addr = 11'h050;
    aq.push_back(mem[11'h050]);
    step();
    aux_addr = 11'h001;
    step();
    step();
    aux_req = 1'b0;
    wait_aux(50, done_c, busy_c);
    check("ign_rdata", 32'(aux_rdata), 32'(mem[11'h050]));
    repeat (5) begin
      step();
      check("ign_no_second_busy", 32'(aux_busy), 32'd0);
    end
    check("ign_rdata_held", 32'(aux_rdata), 32'(mem[11'h050]));

    // Wait counter saturation under a 300-cycle display burst
    for (int i = 0; i < 300; i++) begin
      disp_en = 1'b1;
      disp_addr = AW'(i);
      push_disp(disp_addr);
      if (i == 0) begin
        aux_req = 1'b1;
        aux_addr = 11'h3FF;
        aq.push_back(mem[11'h3FF]);
      end
      step();
      aux_req = 1'b0;
    end
    check("sat_wait", 32'(aux_wait), 32'd255);
    disp_en = 1'b0;
    wait_aux(50, done_c, busy_c);
    check("sat_wait_hold", 32'(aux_wait), 32'd255);
    check("sat_rdata", 32'(aux_rdata), 32'(mem[11'h3FF]));
    repeat (3) step();

    // Reset asserted while the auxiliary read is in WAIT
    aux_req = 1'b1;
    aux_addr = 11'h010;
    step();
    aux_req = 1'b0;
    step();
    rst_n = 1'b0;
    aq.delete();
    #1;
    check("mid_rst_busy", 32'(aux_busy), 32'd0);
    check("mid_rst_done", 32'(aux_done), 32'd0);
    check("mid_rst_rdata", 32'(aux_rdata), 32'd0);
    check("mid_rst_wait", 32'(aux_wait), 32'd0);
    check("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
    check("mid_rst_disp_data", 32'(disp_data), 32'd0);
    check("mid_rst_disp_valid", 32'(disp_valid), 32'd0);
    repeat (3) begin
      step();
      check("mid_rst_no_done", 32'(aux_done), 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      step();
      check("post_rst_no_done", 32'(aux_done), 32'd0);
    end
    aux_req = 1'b1;
    aux_addr = 11'h123;
    aq.push_back(mem[11'h123]);
    req_c = cyc + 1;
    step();
    aux_req = 1'b0;
    wait_aux(50, done_c, busy_c);
    check("post_rst_latency", done_c - req_c, 32'd3);
    check("post_rst_rdata", 32'(aux_rdata), 32'hA5);
    repeat (3) step();

    check("final_disp_q", dq.size(), 32'd0);
    check("final_aux_q", aq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
